// File: rtl/pma_checker_pipe.sv
// Registered, runtime-programmable PMA checker: base/mask/attr table, per-port registered lookup, sticky first-fault record.
// Optional macro PMA_CFG_LOCK_EN: attr bit ATTR_W-1 locks an entry against further writes until reset.
module pma_checker_pipe #(
  parameter int PORTS   = 2,
  parameter int ENTRIES = 8,
  parameter int PADDR_W = 64,
  parameter int ATTR_W  = 8,
  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       check_en,
  input  logic                       cfg_we,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  logic [PADDR_W-1:0]         cfg_base,
  input  logic [PADDR_W-1:0]         cfg_mask,
  input  logic [ATTR_W-1:0]          cfg_attr,
  input  logic                       cfg_valid,
  input  logic [PORTS-1:0]           req_valid_bus,
  output logic [PORTS-1:0]           req_ready_bus,
  input  logic [PORTS*PADDR_W-1:0]   req_paddr_bus,
  input  logic [PORTS*3-1:0]         req_acctype_bus,
  output logic [PORTS-1:0]           resp_valid_bus,
  input  logic [PORTS-1:0]           resp_ready_bus,
  output logic [PORTS-1:0]           resp_allowed_bus,
  output logic [PORTS*ATTR_W-1:0]    resp_attr_bus,
  output logic                       fault_valid,
  output logic [PADDR_W-1:0]         fault_paddr,
  output logic [PORT_W-1:0]          fault_port,
  output logic [2:0]                 fault_acctype,
  input  logic                       fault_clr,
  output logic [15:0]                fault_count
);

  logic [ENTRIES-1:0] ent_valid_q;
  logic [PADDR_W-1:0] ent_base_q [ENTRIES];
  logic [PADDR_W-1:0] ent_mask_q [ENTRIES];
  logic [ATTR_W-1:0]  ent_attr_q [ENTRIES];
  logic [ENTRIES-1:0] ent_wr_en;

  always_comb begin
    ent_wr_en = '0;
    for (int e = 0; e < ENTRIES; e++) begin
`ifdef PMA_CFG_LOCK_EN
      ent_wr_en[e] = cfg_we && (e == int'(cfg_idx)) && !ent_attr_q[e][ATTR_W-1];
`else
      ent_wr_en[e] = cfg_we && (e == int'(cfg_idx));
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < ENTRIES; e++) begin
      if (rst) begin
        ent_valid_q[e] <= 1'b0;
        ent_base_q[e]  <= '0;
        ent_mask_q[e]  <= '0;
        ent_attr_q[e]  <= '0;
      end else if (ent_wr_en[e]) begin
        ent_valid_q[e] <= cfg_valid;
        ent_base_q[e]  <= cfg_base;
        ent_mask_q[e]  <= cfg_mask;
        ent_attr_q[e]  <= cfg_attr;
      end
    end
  end

  // Lookup uses the table as it stands before this edge, so a same-cycle write is not seen.
  logic [ATTR_W-1:0] lk_attr [PORTS];
  logic [PORTS-1:0]  lk_allowed;

  always_comb begin
    lk_allowed = '0;
    for (int p = 0; p < PORTS; p++) begin
      lk_attr[p] = '0;
      for (int e = 0; e < ENTRIES; e++) begin
        if (ent_valid_q[e] &&
            ((ent_base_q[e] ^ req_paddr_bus[p*PADDR_W +: PADDR_W]) & ~ent_mask_q[e]) == '0)
          lk_attr[p] = ent_attr_q[e];
      end
      lk_allowed[p] = check_en ? |(lk_attr[p][2:0] & req_acctype_bus[p*3 +: 3]) : 1'b1;
    end
  end

  logic [PORTS-1:0]  resp_valid_q;
  logic [PORTS-1:0]  resp_allowed_q;
  logic [ATTR_W-1:0] resp_attr_q [PORTS];
  logic [PORTS-1:0]  accept;
  logic [PORTS-1:0]  deny;

  assign req_ready_bus    = ~resp_valid_q | resp_ready_bus;
  assign accept           = req_valid_bus & req_ready_bus;
  assign deny             = accept & ~lk_allowed;
  assign resp_valid_bus   = resp_valid_q;
  assign resp_allowed_bus = resp_allowed_q;

  always_comb begin
    resp_attr_bus = '0;
    for (int p = 0; p < PORTS; p++) resp_attr_bus[p*ATTR_W +: ATTR_W] = resp_attr_q[p];
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (rst) begin
        resp_valid_q[p]   <= 1'b0;
        resp_allowed_q[p] <= 1'b0;
        resp_attr_q[p]    <= '0;
      end else if (accept[p]) begin
        resp_valid_q[p]   <= 1'b1;
        resp_allowed_q[p] <= lk_allowed[p];
        resp_attr_q[p]    <= lk_attr[p];
      end else if (resp_ready_bus[p]) begin
        resp_valid_q[p]   <= 1'b0;
      end
    end
  end

  logic               fault_valid_q, fault_valid_d;
  logic [PADDR_W-1:0] fault_paddr_q, fault_paddr_d;
  logic [PORT_W-1:0]  fault_port_q, fault_port_d;
  logic [2:0]         fault_acc_q, fault_acc_d;
  logic [15:0]        fault_count_q, fault_count_d;
  logic [16:0]        deny_n, cnt_sum;
  logic [PADDR_W-1:0] first_paddr;
  logic [PORT_W-1:0]  first_port;
  logic [2:0]         first_acc;
  logic               fv_base;

  // Clear is applied first so a denial in the same cycle still lands in the record and count.
  always_comb begin
    deny_n      = '0;
    first_paddr = '0;
    first_port  = '0;
    first_acc   = '0;
    for (int p = PORTS-1; p >= 0; p--) begin
      if (deny[p]) begin
        deny_n      = deny_n + 17'd1;
        first_paddr = req_paddr_bus[p*PADDR_W +: PADDR_W];
        first_port  = PORT_W'(p);
        first_acc   = req_acctype_bus[p*3 +: 3];
      end
    end
    fv_base       = fault_clr ? 1'b0 : fault_valid_q;
    cnt_sum       = {1'b0, (fault_clr ? 16'd0 : fault_count_q)} + deny_n;
    fault_count_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    fault_valid_d = fv_base | (|deny);
    fault_paddr_d = fault_paddr_q;
    fault_port_d  = fault_port_q;
    fault_acc_d   = fault_acc_q;
    if (!fv_base && (|deny)) begin
      fault_paddr_d = first_paddr;
      fault_port_d  = first_port;
      fault_acc_d   = first_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_valid_q <= 1'b0;
      fault_paddr_q <= '0;
      fault_port_q  <= '0;
      fault_acc_q   <= '0;
      fault_count_q <= '0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_paddr_q <= fault_paddr_d;
      fault_port_q  <= fault_port_d;
      fault_acc_q   <= fault_acc_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign fault_valid   = fault_valid_q;
  assign fault_paddr   = fault_paddr_q;
  assign fault_port    = fault_port_q;
  assign fault_acctype = fault_acc_q;
  assign fault_count   = fault_count_q;

endmodule
